// File: rtl/gr_bank_mp_pkg.sv
// Shared types and constants for the multi-port general-register bank.
package gr_bank_mp_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned IDXW = $clog2(NREG);

    typedef logic [IDXW-1:0] gr_idx_t;
    typedef logic [XLEN-1:0] word_t;

    localparam word_t PSW_RST = 32'h0000_0020;

    typedef enum logic [1:0] {WP_EX0, WP_EX1, WP_MEM} wr_port_e;

endpackage

// File: rtl/gr_bank_mp_scoreboard.sv
// Per-register outstanding-load counters with sticky error flag.
// Drives read-port readiness and the load-issue full indication.
module gr_bank_mp_scoreboard #(
    parameter int unsigned NREG   = 32,
    parameter int unsigned IDXW   = 5,
    parameter int unsigned NRD    = 3,
    parameter int unsigned PEND_W = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ld_iss_i,
    input  logic [IDXW-1:0]           ld_idx_i,
    input  logic                      ldw_en_i,
    input  logic [IDXW-1:0]           ldw_idx_i,
    input  logic [NRD-1:0][IDXW-1:0]  rd_idx_i,
    output logic [NRD-1:0]            rd_rdy_o,
    output logic                      ld_full_o,
    output logic                      sb_err_o
);

    localparam logic [PEND_W-1:0] CNT_MAX = '1;
    localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

    logic [PEND_W-1:0] r_cnt [NREG];
    logic [PEND_W-1:0] w_cnt_d [NREG];
    logic [NREG-1:0]   w_iss_hit, w_ldw_hit, w_inc, w_dec;
    logic              r_err, w_err_d;

    // An issue at MAX is accepted when a load write-back frees a slot in the same cycle.
    always_comb begin
        w_err_d   = r_err;
        w_iss_hit = '0;
        w_ldw_hit = '0;
        w_inc     = '0;
        w_dec     = '0;
        for (int r = 0; r < NREG; r++) begin
            w_cnt_d[r]   = r_cnt[r];
            w_iss_hit[r] = ld_iss_i && (ld_idx_i == IDXW'(r)) && (r != 0);
            w_ldw_hit[r] = ldw_en_i && (ldw_idx_i == IDXW'(r)) && (r != 0);
            w_dec[r]     = w_ldw_hit[r] && (r_cnt[r] != '0);
            w_inc[r]     = w_iss_hit[r] && ((r_cnt[r] != CNT_MAX) || w_dec[r]);
            if (w_inc[r] && !w_dec[r]) begin
                w_cnt_d[r] = r_cnt[r] + 1'b1;
            end else if (w_dec[r] && !w_inc[r]) begin
                w_cnt_d[r] = r_cnt[r] - 1'b1;
            end
            if ((w_iss_hit[r] && !w_inc[r]) || (w_ldw_hit[r] && (r_cnt[r] == '0))) begin
                w_err_d = 1'b1;
            end
        end
    end

    always_comb begin
        rd_rdy_o = '0;
        for (int p = 0; p < NRD; p++) begin
            rd_rdy_o[p] = (r_cnt[rd_idx_i[p]] == '0) ||
                          ((r_cnt[rd_idx_i[p]] == CNT_ONE) && ldw_en_i &&
                           (ldw_idx_i == rd_idx_i[p]));
        end
        ld_full_o = (r_cnt[ld_idx_i] == CNT_MAX) && !(ldw_en_i && (ldw_idx_i == ld_idx_i));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                r_cnt[r] <= '0;
            end
            r_err <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                r_cnt[r] <= w_cnt_d[r];
            end
            r_err <= w_err_d;
        end
    end

    assign sb_err_o = r_err;

endmodule

// File: rtl/gr_bank_mp.sv
// Multi-port general-register bank with write bypass, PSW and load scoreboard.
// The highest-numbered write port (MEM) is the load write-back port.
module gr_bank_mp
    import gr_bank_mp_pkg::*;
#(
    parameter int unsigned XLEN   = gr_bank_mp_pkg::XLEN,
    parameter int unsigned NREG   = gr_bank_mp_pkg::NREG,
    parameter int unsigned NRD    = 3,
    parameter int unsigned NWR    = 3,
    parameter int unsigned PEND_W = 2,
    parameter int unsigned IDXW   = $clog2(NREG)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NRD-1:0][IDXW-1:0]  rd_idx_i,
    output logic [NRD-1:0][XLEN-1:0]  rd_data_o,
    output logic [NRD-1:0]            rd_rdy_o,
    input  logic [NWR-1:0]            wr_en_i,
    input  logic [NWR-1:0][IDXW-1:0]  wr_idx_i,
    input  logic [NWR-1:0][XLEN-1:0]  wr_data_i,
    input  logic                      ld_iss_i,
    input  logic [IDXW-1:0]           ld_idx_i,
    output logic                      ld_full_o,
    input  logic                      psw_we_i,
    input  logic [XLEN-1:0]           psw_wd_i,
    output logic [XLEN-1:0]           psw_o,
    output logic                      sb_err_o
);

    localparam int unsigned LD_PORT = NWR - 1;

    logic [XLEN-1:0] r_gr [NREG];
    logic [XLEN-1:0] r_psw;

    // Later ports overwrite earlier ones, so the highest enabled port wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                r_gr[r] <= '0;
            end
            r_psw <= XLEN'(PSW_RST);
        end else begin
            for (int p = 0; p < NWR; p++) begin
                if (wr_en_i[p] && (wr_idx_i[p] != '0)) begin
                    r_gr[wr_idx_i[p]] <= wr_data_i[p];
                end
            end
            if (psw_we_i) begin
                r_psw <= psw_wd_i;
            end
        end
    end

    always_comb begin
        rd_data_o = '0;
        for (int q = 0; q < NRD; q++) begin
            rd_data_o[q] = r_gr[rd_idx_i[q]];
            for (int p = 0; p < NWR; p++) begin
                if (wr_en_i[p] && (wr_idx_i[p] == rd_idx_i[q])) begin
                    rd_data_o[q] = wr_data_i[p];
                end
            end
            if (rd_idx_i[q] == '0) begin
                rd_data_o[q] = '0;
            end
        end
    end

    assign psw_o = r_psw;

    gr_bank_mp_scoreboard #(
        .NREG   (NREG),
        .IDXW   (IDXW),
        .NRD    (NRD),
        .PEND_W (PEND_W)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .ld_iss_i  (ld_iss_i),
        .ld_idx_i  (ld_idx_i),
        .ldw_en_i  (wr_en_i[LD_PORT]),
        .ldw_idx_i (wr_idx_i[LD_PORT]),
        .rd_idx_i  (rd_idx_i),
        .rd_rdy_o  (rd_rdy_o),
        .ld_full_o (ld_full_o),
        .sb_err_o  (sb_err_o)
    );

endmodule

// File: tb/tb_gr_bank_mp.sv
// Bench for gr_bank_mp: vector table, directed multi-cycle sequences, random vs. reference model.
module tb_gr_bank_mp;

    logic            clk = 1'b0;
    logic            rst;
    logic [2:0][4:0]  rd_idx;
    logic [2:0][31:0] rd_data;
    logic [2:0]       rd_rdy;
    logic [2:0]       wr_en;
    logic [2:0][4:0]  wr_idx;
    logic [2:0][31:0] wr_data;
    logic             ld_iss;
    logic [4:0]       ld_idx;
    logic             ld_full;
    logic             psw_we;
    logic [31:0]      psw_wd;
    logic [31:0]      psw_o;
    logic             sb_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    gr_bank_mp dut (
        .clk       (clk),
        .rst       (rst),
        .rd_idx_i  (rd_idx),
        .rd_data_o (rd_data),
        .rd_rdy_o  (rd_rdy),
        .wr_en_i   (wr_en),
        .wr_idx_i  (wr_idx),
        .wr_data_i (wr_data),
        .ld_iss_i  (ld_iss),
        .ld_idx_i  (ld_idx),
        .ld_full_o (ld_full),
        .psw_we_i  (psw_we),
        .psw_wd_i  (psw_wd),
        .psw_o     (psw_o),
        .sb_err_o  (sb_err)
    );

    typedef struct {
        logic [2:0]  en;
        logic [4:0]  i0, i1;
        logic [31:0] d0, d1;
        logic [4:0]  ra;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[6];

    // Reference model state
    logic [31:0] m_gr [32];
    int          m_cnt [32];
    logic [31:0] m_psw;
    logic        m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_idx = '0; wr_en = '0; wr_idx = '0; wr_data = '0;
        ld_iss = 0; ld_idx = '0; psw_we = 0; psw_wd = '0;
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            m_gr[r] = '0;
            m_cnt[r] = 0;
        end
        m_psw = 32'h20;
        m_err = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] idx);
        logic [31:0] v;
        if (idx == 0) return '0;
        v = m_gr[idx];
        for (int p = 0; p < 3; p++) if (wr_en[p] && wr_idx[p] == idx) v = wr_data[p];
        return v;
    endfunction

    function automatic logic m_ready(input logic [4:0] idx);
        if (idx == 0 || m_cnt[idx] == 0) return 1'b1;
        return (m_cnt[idx] == 1) && wr_en[2] && (wr_idx[2] == idx);
    endfunction

    // Applies one clock edge of the current inputs to the model.
    task automatic model_step();
        int  old_cnt, ldw_hits, dec, inc_ok;
        if (rst) begin
            model_reset();
            return;
        end
        for (int p = 0; p < 3; p++) if (wr_en[p] && wr_idx[p] != 0) m_gr[wr_idx[p]] = wr_data[p];
        if (psw_we) m_psw = psw_wd;
        for (int r = 1; r < 32; r++) begin
            old_cnt  = m_cnt[r];
            ldw_hits = (wr_en[2] && wr_idx[2] == r) ? 1 : 0;
            dec      = (ldw_hits == 1 && old_cnt > 0) ? 1 : 0;
            if (ldw_hits == 1 && old_cnt == 0) m_err = 1;
            inc_ok = 0;
            if (ld_iss && ld_idx == r) begin
                if (old_cnt < 3 || dec == 1) inc_ok = 1;
                else m_err = 1;
            end
            m_cnt[r] = old_cnt + inc_ok - dec;
        end
    endtask

    initial begin
        tbl[0] = '{en: 3'b011, i0: 5, i1: 5, d0: 32'h1234, d1: 32'hBEEF, ra: 5, exp: 32'hBEEF};
        tbl[1] = '{en: 3'b000, i0: 0, i1: 0, d0: 0, d1: 0, ra: 5, exp: 32'hBEEF};
        tbl[2] = '{en: 3'b001, i0: 0, i1: 0, d0: 32'hDEAD, d1: 0, ra: 0, exp: 32'h0};
        tbl[3] = '{en: 3'b000, i0: 0, i1: 0, d0: 0, d1: 0, ra: 0, exp: 32'h0};
        tbl[4] = '{en: 3'b011, i0: 6, i1: 6, d0: 32'h1, d1: 32'h2, ra: 6, exp: 32'h2};
        tbl[5] = '{en: 3'b001, i0: 8, i1: 0, d0: 32'h77, d1: 0, ra: 6, exp: 32'h2};

        idle();
        rst = 1;
        tick();
        tick();
        rst = 0;

        // Reset state
        rd_idx = {5'd3, 5'd2, 5'd1};
        #1;
        for (int q = 0; q < 3; q++) check("reset_rd_data", rd_data[q], 32'h0);
        check("reset_rd_rdy", {29'd0, rd_rdy}, 32'h7);
        check("reset_ld_full", {31'd0, ld_full}, 32'h0);
        check("reset_psw", psw_o, 32'h20);
        check("reset_sb_err", {31'd0, sb_err}, 32'h0);

        // Write collisions, bypass and r0 discard
        for (int i = 0; i < 6; i++) begin
            idle();
            wr_en = tbl[i].en;
            wr_idx[0] = tbl[i].i0; wr_data[0] = tbl[i].d0;
            wr_idx[1] = tbl[i].i1; wr_data[1] = tbl[i].d1;
            rd_idx[0] = tbl[i].ra; rd_idx[2] = tbl[i].ra;
            #1;
            check("tbl_rd0", rd_data[0], tbl[i].exp);
            check("tbl_rd2", rd_data[2], tbl[i].exp);
            tick();
        end
        idle();
        rd_idx[1] = 8;
        #1;
        check("tbl_r8_stored", rd_data[1], 32'h77);

        // Two loads to r7, ready only on the second write-back
        idle();
        ld_iss = 1; ld_idx = 7;
        tick();
        tick();
        ld_iss = 0;
        rd_idx[0] = 7;
        #1;
        check("ld2_rdy_before", {31'd0, rd_rdy[0]}, 0);
        wr_en = 3'b100; wr_idx[2] = 7; wr_data[2] = 32'hA5;
        #1;
        check("ld2_rdy_wb1", {31'd0, rd_rdy[0]}, 0);
        check("ld2_data_wb1", rd_data[0], 32'hA5);
        tick();
        wr_en = '0;
        #1;
        check("ld2_rdy_mid", {31'd0, rd_rdy[0]}, 0);
        wr_en = 3'b100;
        #1;
        check("ld2_rdy_wb2", {31'd0, rd_rdy[0]}, 1);
        check("ld2_data_wb2", rd_data[0], 32'hA5);
        tick();
        wr_en = '0;
        #1;
        check("ld2_rdy_after", {31'd0, rd_rdy[0]}, 1);
        check("ld2_no_err", {31'd0, sb_err}, 0);

        // Saturation on r9
        idle();
        ld_iss = 1; ld_idx = 9;
        tick(); tick(); tick();
        ld_iss = 0;
        #1;
        check("sat_full", {31'd0, ld_full}, 1);
        ld_iss = 1; wr_en = 3'b100; wr_idx[2] = 9; wr_data[2] = 32'h99;
        #1;
        check("sat_full_masked", {31'd0, ld_full}, 0);
        tick();
        ld_iss = 0; wr_en = '0;
        #1;
        check("sat_swap_full", {31'd0, ld_full}, 1);
        check("sat_swap_no_err", {31'd0, sb_err}, 0);
        ld_iss = 1;
        tick();
        ld_iss = 0;
        #1;
        check("sat_over_err", {31'd0, sb_err}, 1);
        check("sat_over_full", {31'd0, ld_full}, 1);
        wr_en = 3'b100;
        tick();
        wr_en = '0;
        #1;
        check("sat_drain_full", {31'd0, ld_full}, 0);

        // Unexpected write-back and mid-operation reset
        idle();
        rst = 1; tick(); rst = 0;
        wr_en = 3'b100; wr_idx[2] = 4; wr_data[2] = 32'h44;
        tick();
        wr_en = '0; rd_idx[0] = 4;
        #1;
        check("stray_wb_data", rd_data[0], 32'h44);
        check("stray_wb_err", {31'd0, sb_err}, 1);
        ld_iss = 1; ld_idx = 10;
        tick();
        ld_iss = 0; rd_idx[1] = 10;
        #1;
        check("pend_r10_rdy", {31'd0, rd_rdy[1]}, 0);
        rst = 1; tick(); rst = 0;
        #1;
        check("rst_r10_rdy", {31'd0, rd_rdy[1]}, 1);
        check("rst_err_clr", {31'd0, sb_err}, 0);

        // PSW is registered, not bypassed
        psw_we = 1; psw_wd = 32'h5;
        #1;
        check("psw_write_cycle", psw_o, 32'h20);
        tick();
        psw_we = 0;
        #1;
        check("psw_next_cycle", psw_o, 32'h5);

        // Randomized run against the reference model
        idle();
        rst = 1; tick(); rst = 0;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            for (int q = 0; q < 3; q++) rd_idx[q] = 5'($urandom_range(0, 7));
            for (int p = 0; p < 3; p++) begin
                wr_en[p]   = ($urandom_range(0, 2) == 0);
                wr_idx[p]  = 5'($urandom_range(0, 7));
                wr_data[p] = $urandom;
            end
            ld_iss = ($urandom_range(0, 2) == 0);
            ld_idx = 5'($urandom_range(0, 7));
            psw_we = ($urandom_range(0, 7) == 0);
            psw_wd = $urandom;
            #1;
            for (int q = 0; q < 3; q++) begin
                check("rnd_rd_data", rd_data[q], m_read(rd_idx[q]));
                check("rnd_rd_rdy", {31'd0, rd_rdy[q]}, {31'd0, m_ready(rd_idx[q])});
            end
            check("rnd_ld_full", {31'd0, ld_full},
                  {31'd0, (ld_idx != 0) && (m_cnt[ld_idx] == 3) &&
                          !(wr_en[2] && wr_idx[2] == ld_idx)});
            check("rnd_psw", psw_o, m_psw);
            check("rnd_sb_err", {31'd0, sb_err}, {31'd0, m_err});
            model_step();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
